// File: rtl/cpu_mem_pkg.sv
// Shared constants for the CPU memory responder.
//   DONE_ADDR_DEFAULT : byte address whose write signals program completion
//   NOP_INSTR         : instruction returned for out-of-range fetches
//   ERR_*             : bit positions inside the sticky err vector
package cpu_mem_pkg;
  localparam logic [31:0] DONE_ADDR_DEFAULT = 32'h0000_FFFC;
  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam int ERR_OOB      = 0;
  localparam int ERR_MISALIGN = 1;
  localparam int ERR_COLLIDE  = 2;

  // A byte address is in range when every bit above the word index is zero.
  function automatic logic addr_in_range(input logic [31:0] addr, input int aw);
    return (addr >> (aw + 2)) == 32'd0;
  endfunction
endpackage

// File: rtl/cpu_mem_lane.sv
// One byte lane of the responder memory: 2^ADDR_WIDTH bytes, one write port,
// two synchronous read ports (a = fetch, b = data) with enables.
// Ports: clk, rst (clears read registers only), we/waddr/wdata,
//        re_a/raddr_a/rdata_a, re_b/raddr_b/rdata_b.
module cpu_mem_lane #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic                  re_a,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [7:0]            rdata_a,
  input  logic                  re_b,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [7:0]            rdata_b
);
  logic [7:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Array is never cleared; reset only affects the read registers.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Reads sample the array before this edge's write lands (old data).
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a <= 8'h00;
      rdata_b <= 8'h00;
    end else begin
      if (re_a) rdata_a <= mem[raddr_a];
      if (re_b) rdata_b <= mem[raddr_b];
    end
  end
endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for a multi-cycle RV32 CPU.
// Ports: clk/rst; instr_read/instr_addr -> instr_out (1-cycle registered);
//        data_read/data_addr/data_write/data_in -> data_out (1-cycle registered);
//        load_en/load_addr/load_data word preload; done/done_code completion
//        flag; err sticky {collide, misalign, oob}; wr_cnt saturating count.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] DONE_ADDR  = DONE_ADDR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_read,
  input  logic [31:0]           instr_addr,
  output logic [31:0]           instr_out,
  input  logic                  data_read,
  input  logic [31:0]           data_addr,
  input  logic [3:0]            data_write,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [31:0]           load_data,
  output logic                  done,
  output logic [31:0]           done_code,
  output logic [2:0]            err,
  output logic [31:0]           wr_cnt
);
  logic [ADDR_WIDTH-1:0] instr_idx, data_idx;
  logic instr_ok, data_ok, is_done;
  logic wr_any, wr_accept, wr_done, wr_misal, wr_oob;
  logic fetch_mem, dread, dread_mem;
  logic [2:0] err_set;
  logic [3:0][7:0] instr_rd, data_rd;
  // Output selects: fetch either from memory or the NOP constant; data read
  // either from memory or a single status bit (0 for oob, done for DONE_ADDR).
  logic instr_nop_q, data_mem_q, data_bit_q;

  assign instr_idx = instr_addr[ADDR_WIDTH+1:2];
  assign data_idx  = data_addr[ADDR_WIDTH+1:2];
  assign instr_ok  = addr_in_range(instr_addr, ADDR_WIDTH);
  assign data_ok   = addr_in_range(data_addr, ADDR_WIDTH);
  assign is_done   = (data_addr == DONE_ADDR);
  assign wr_any    = |data_write;

  // Write classification, highest priority first: preload collision, done
  // address, misaligned full word, out of range, else accepted.
  always_comb begin
    wr_done   = 1'b0;
    wr_misal  = 1'b0;
    wr_oob    = 1'b0;
    wr_accept = 1'b0;
    if (wr_any && !load_en) begin
      if (is_done)                                           wr_done   = 1'b1;
      else if (data_write == 4'hF && data_addr[1:0] != 2'b00) wr_misal = 1'b1;
      else if (!data_ok)                                     wr_oob    = 1'b1;
      else                                                   wr_accept = 1'b1;
    end
  end

  assign fetch_mem = instr_read & instr_ok;
  assign dread     = data_read & ~wr_any;
  assign dread_mem = dread & ~is_done & data_ok;

  always_comb begin
    err_set               = 3'b000;
    err_set[ERR_COLLIDE]  = wr_any & load_en;
    err_set[ERR_MISALIGN] = wr_misal;
    err_set[ERR_OOB]      = (instr_read & ~instr_ok) | (dread & ~is_done & ~data_ok) | wr_oob;
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic                  lane_we;
    logic [ADDR_WIDTH-1:0] lane_waddr;
    logic [7:0]            lane_wdata;
    // Preload owns the write port whenever asserted; nothing commits in reset.
    assign lane_we    = ~rst & (load_en | (wr_accept & data_write[i]));
    assign lane_waddr = load_en ? load_addr : data_idx;
    assign lane_wdata = load_en ? load_data[8*i +: 8] : data_in[8*i +: 8];

    cpu_mem_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .we      (lane_we),
      .waddr   (lane_waddr),
      .wdata   (lane_wdata),
      .re_a    (fetch_mem),
      .raddr_a (instr_idx),
      .rdata_a (instr_rd[i]),
      .re_b    (dread_mem),
      .raddr_b (data_idx),
      .rdata_b (data_rd[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_nop_q <= 1'b0;
      data_mem_q  <= 1'b0;
      data_bit_q  <= 1'b0;
      done        <= 1'b0;
      done_code   <= 32'd0;
      err         <= 3'b000;
      wr_cnt      <= 32'd0;
    end else begin
      if (instr_read) instr_nop_q <= ~instr_ok;
      if (dread) begin
        data_mem_q <= dread_mem;
        data_bit_q <= is_done & done;
      end
      if (wr_done) begin
        done      <= 1'b1;
        done_code <= data_in;
      end
      if (wr_accept && wr_cnt != 32'hFFFF_FFFF) wr_cnt <= wr_cnt + 32'd1;
      err <= err | err_set;
    end
  end

  assign instr_out = instr_nop_q ? NOP_INSTR : instr_rd;
  assign data_out  = data_mem_q ? data_rd : {31'b0, data_bit_q};
endmodule

// File: tb/tb_cpu_mem_responder.sv
module tb_cpu_mem_responder;
  localparam int AW = 14;
  localparam logic [31:0] DONE = 32'h0000_FFFC;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int NPRE = 192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, instr_read, data_read, load_en, done;
  logic [31:0] instr_addr, instr_out, data_addr, data_in, data_out, load_data, done_code, wr_cnt;
  logic [3:0] data_write;
  logic [AW-1:0] load_addr;
  logic [2:0] err;

  int tests = 0, fails = 0;

  // Behavioural model: word memory plus expected output registers.
  logic [31:0] m_mem [int];
  logic [31:0] m_instr, m_data, m_code, m_cnt;
  logic m_done;
  logic [2:0] m_err;

  cpu_mem_responder #(.ADDR_WIDTH(AW), .DONE_ADDR(DONE)) dut (
    .clk(clk), .rst(rst), .instr_read(instr_read), .instr_addr(instr_addr),
    .instr_out(instr_out), .data_read(data_read), .data_addr(data_addr),
    .data_write(data_write), .data_in(data_in), .data_out(data_out),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .done(done), .done_code(done_code), .err(err), .wr_cnt(wr_cnt)
  );

  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'h0001_0000;
  endfunction

  // One clock of the spec'd behaviour, evaluated from the inputs at the edge.
  task automatic model_step();
    logic [31:0] w;
    int idx;
    if (rst) begin
      m_instr = 0; m_data = 0; m_code = 0; m_cnt = 0; m_done = 0; m_err = 0;
      return;
    end
    if (instr_read) begin
      if (in_rng(instr_addr)) m_instr = m_mem[int'(instr_addr / 4)];
      else begin m_instr = NOP; m_err[0] = 1; end
    end
    if (data_read && data_write == 0) begin
      if (data_addr == DONE) m_data = {31'b0, m_done};
      else if (in_rng(data_addr)) m_data = m_mem[int'(data_addr / 4)];
      else begin m_data = 0; m_err[0] = 1; end
    end
    if (data_write != 0) begin
      if (load_en) m_err[2] = 1;
      else if (data_addr == DONE) begin m_done = 1; m_code = data_in; end
      else if (data_write == 4'hF && data_addr % 4 != 0) m_err[1] = 1;
      else if (!in_rng(data_addr)) m_err[0] = 1;
      else begin
        idx = int'(data_addr / 4);
        w = m_mem[idx];
        for (int b = 0; b < 4; b++)
          if (data_write[b]) w[8*b +: 8] = data_in[8*b +: 8];
        m_mem[idx] = w;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
    end
    if (load_en) m_mem[int'(load_addr)] = load_data;
  endtask

  task automatic idle();
    rst = 0; instr_read = 0; instr_addr = 0; data_read = 0; data_addr = 0;
    data_write = 0; data_in = 0; load_en = 0; load_addr = 0; load_data = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    model_step();
  endtask

  task automatic test_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
    tests++; if (instr_out !== 0) begin fails++; $display("FAIL reset_instr got %h want 0", instr_out); end
    tests++; if (data_out !== 0) begin fails++; $display("FAIL reset_data got %h want 0", data_out); end
    tests++; if ({done, err} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b want 0", {done, err}); end
    tests++; if (wr_cnt !== 0 || done_code !== 0) begin fails++; $display("FAIL reset_cnt got %h/%h want 0/0", wr_cnt, done_code); end
  endtask

  task automatic preload();
    logic [31:0] v;
    for (int i = 0; i < NPRE; i++) begin
      idle(); load_en = 1; load_addr = AW'(i);
      v = $urandom;
      if (i == 0) v = 32'h0050_0093;
      if (i == 1) v = 32'h1234_5678;
      if (i == 64) v = 32'h0;
      load_data = v;
      tick();
    end
    idle(); rst = 1; tick(); idle();
  endtask

  task automatic test_fetch();
    instr_read = 1; instr_addr = 0; #1;
    tests++; if (instr_out !== 0) begin fails++; $display("FAIL fetch_latency got %h want 0", instr_out); end
    tick();
    tests++; if (instr_out !== 32'h0050_0093) begin fails++; $display("FAIL fetch0 got %h want 00500093", instr_out); end
    instr_addr = 4; tick();
    tests++; if (instr_out !== 32'h1234_5678) begin fails++; $display("FAIL fetch4 got %h want 12345678", instr_out); end
    instr_read = 0; instr_addr = 0; tick();
    tests++; if (instr_out !== 32'h1234_5678) begin fails++; $display("FAIL fetch_hold got %h want 12345678", instr_out); end
  endtask

  task automatic test_partial_write();
    idle(); data_addr = 32'h100; data_write = 4'b0101; data_in = 32'hAABB_CCDD; data_read = 1; tick();
    tests++; if (data_out !== 0) begin fails++; $display("FAIL wr_holds_dout got %h want 0", data_out); end
    idle(); data_read = 1; data_addr = 32'h100; tick();
    tests++; if (data_out !== 32'h00BB_00DD) begin fails++; $display("FAIL partial_wr got %h want 00bb00dd", data_out); end
    tests++; if (wr_cnt !== 1) begin fails++; $display("FAIL partial_cnt got %0d want 1", wr_cnt); end
  endtask

  task automatic test_misalign();
    idle(); data_addr = 32'h102; data_write = 4'hF; data_in = 32'h1122_3344; tick();
    idle(); data_read = 1; data_addr = 32'h100; tick();
    tests++; if (data_out !== 32'h00BB_00DD) begin fails++; $display("FAIL misal_mem got %h want 00bb00dd", data_out); end
    tests++; if (err !== 3'b010) begin fails++; $display("FAIL misal_err got %b want 010", err); end
    tests++; if (wr_cnt !== 1) begin fails++; $display("FAIL misal_cnt got %0d want 1", wr_cnt); end
  endtask

  task automatic test_done();
    idle(); data_addr = DONE; data_write = 4'hF; data_in = 32'h1; tick();
    tests++; if (done !== 1 || done_code !== 1) begin fails++; $display("FAIL done_set got %b/%h want 1/1", done, done_code); end
    tests++; if (wr_cnt !== 1) begin fails++; $display("FAIL done_cnt got %0d want 1", wr_cnt); end
    idle(); data_read = 1; data_addr = DONE; tick();
    tests++; if (data_out !== 1) begin fails++; $display("FAIL done_read got %h want 1", data_out); end
  endtask

  task automatic test_collide();
    logic [31:0] old128;
    old128 = m_mem[128];
    idle(); load_en = 1; load_addr = AW'(5); load_data = 32'hDEAD_BEEF;
    data_addr = 32'h200; data_write = 4'hF; data_in = 32'h5555_5555; tick();
    tests++; if (err[2] !== 1'b1) begin fails++; $display("FAIL collide_err got %b want 1xx", err); end
    idle(); instr_read = 1; instr_addr = 32'h14; data_read = 1; data_addr = 32'h200; tick();
    tests++; if (instr_out !== 32'hDEAD_BEEF) begin fails++; $display("FAIL collide_load got %h want deadbeef", instr_out); end
    tests++; if (data_out !== old128) begin fails++; $display("FAIL collide_drop got %h want %h", data_out, old128); end
    idle(); instr_read = 1; instr_addr = 32'h0004_0000; tick();
    tests++; if (instr_out !== NOP) begin fails++; $display("FAIL oob_fetch got %h want 00000013", instr_out); end
    tests++; if (err[0] !== 1'b1) begin fails++; $display("FAIL oob_err got %b want xx1", err); end
  endtask

  task automatic test_rdw();
    logic [31:0] oldv;
    oldv = m_mem[2];
    idle(); instr_read = 1; instr_addr = 32'h8; data_addr = 32'h8; data_write = 4'hF; data_in = ~oldv; tick();
    tests++; if (instr_out !== oldv) begin fails++; $display("FAIL rdw_old got %h want %h", instr_out, oldv); end
    idle(); instr_read = 1; instr_addr = 32'h8; tick();
    tests++; if (instr_out !== ~oldv) begin fails++; $display("FAIL rdw_new got %h want %h", instr_out, ~oldv); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 59) == 0);
      instr_read = $urandom_range(0, 1);
      instr_addr = ($urandom_range(0, 7) == 0) ? {$urandom_range(1, 65535), 16'h0} + 32'($urandom_range(0, 65535))
                                               : 32'($urandom_range(0, NPRE * 4 - 1));
      case ($urandom_range(0, 7))
        6:       data_addr = DONE;
        7:       data_addr = 32'h0001_0000 + $urandom_range(0, 32'h00FF_FFFF);
        default: data_addr = 32'($urandom_range(0, NPRE * 4 - 1));
      endcase
      data_read = $urandom_range(0, 1);
      data_write = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      data_in = $urandom;
      load_en = ($urandom_range(0, 7) == 0);
      load_addr = AW'($urandom_range(0, NPRE - 1));
      load_data = $urandom;
      tick();
      tests++; if (instr_out !== m_instr) begin fails++; $display("FAIL rnd_instr cyc %0d got %h want %h", n, instr_out, m_instr); end
      tests++; if (data_out !== m_data) begin fails++; $display("FAIL rnd_data cyc %0d got %h want %h", n, data_out, m_data); end
      tests++; if ({done, err} !== {m_done, m_err}) begin fails++; $display("FAIL rnd_flags cyc %0d got %b want %b", n, {done, err}, {m_done, m_err}); end
      tests++; if (done_code !== m_code || wr_cnt !== m_cnt) begin fails++; $display("FAIL rnd_code_cnt cyc %0d got %h/%0d want %h/%0d", n, done_code, wr_cnt, m_code, m_cnt); end
    end
  endtask

  task automatic test_final_reset();
    idle(); data_addr = DONE; data_write = 4'hF; data_in = 32'h77; instr_read = 1; instr_addr = 32'h0010_0000; tick();
    tests++; if (done !== 1 || err == 0) begin fails++; $display("FAIL prereset got done=%b err=%b want 1/nonzero", done, err); end
    idle(); rst = 1; tick();
    tests++; if ({instr_out, data_out, done_code, wr_cnt, done, err} !== '0) begin fails++;
      $display("FAIL rst_outputs got %h %h %h %h %b %b want all 0", instr_out, data_out, done_code, wr_cnt, done, err); end
    idle(); instr_read = 1; instr_addr = 32'h4; data_read = 1; data_addr = 32'h14; tick();
    tests++; if (instr_out !== m_mem[1]) begin fails++; $display("FAIL rst_mem_instr got %h want %h", instr_out, m_mem[1]); end
    tests++; if (data_out !== m_mem[5]) begin fails++; $display("FAIL rst_mem_data got %h want %h", data_out, m_mem[5]); end
  endtask

  initial begin
    test_reset();
    preload();
    test_fetch();
    test_partial_write();
    test_misalign();
    test_done();
    test_collide();
    test_rdw();
    test_random();
    test_final_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
